instruction_fetch_unit: RTL and testbench

//  Upstream fetch stage for the CPU core. Owns the program counter and drives the

---
 rtl/instruction_fetch_unit.sv | 73 +++++++
 tb/tb_instruction_fetch_unit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, registers each fetched word and hands it
// downstream over valid/ready, with redirect flush and HALT/resume.
module instruction_fetch_unit #(
  parameter int ADDR_WIDTH = 4,
  parameter int INSTR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter logic [3:0] HALT_OPCODE = 4'hF
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_addr,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic                   halted,
  input  logic                   resume
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  slot_free;
  logic                  is_halt;

  assign slot_free = !instr_valid || instr_ready;
  assign is_halt   = imem_data[INSTR_WIDTH-1 -: 4] == HALT_OPCODE;
  assign imem_addr = pc;
  // HALT word must be accepted before the stage reports halted
  assign halted    = (state == HALT) && !instr_valid;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc          <= RESET_PC;
      state       <= RUN;
      instr_valid <= 1'b0;
      instr_out   <= '0;
      instr_pc    <= '0;
    end else if (redirect_valid) begin
      pc          <= redirect_addr;
      instr_valid <= 1'b0;
      state       <= RUN;
    end else begin
      unique case (state)
        HALT: begin
          if (halted && resume)
            state <= RUN;
          else if (instr_valid && instr_ready)
            instr_valid <= 1'b0;
        end
        RUN: begin
          if (slot_free) begin
            instr_out   <= imem_data;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            pc          <= pc + 1'b1;
            if (is_halt)
              state <= HALT;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: stream, stall, halt,
// redirect, wrap and reset-over-redirect.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  imem_addr;
  logic [15:0] imem_data;
  logic        redirect_valid;
  logic [3:0]  redirect_addr;
  logic [15:0] instr_out;
  logic [3:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        halted;
  logic        resume;

  logic [15:0] mem [16];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  instruction_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .halted         (halted),
    .resume         (resume)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input string tag, input logic [15:0] w,
                             input logic [3:0] p, input logic [3:0] a);
    chk({tag, ".valid"}, 32'(instr_valid), 32'd1);
    chk({tag, ".out"}, 32'(instr_out), 32'(w));
    chk({tag, ".pc"}, 32'(instr_pc), 32'(p));
    chk({tag, ".addr"}, 32'(imem_addr), 32'(a));
    chk({tag, ".halted"}, 32'(halted), 32'd0);
  endtask

  task automatic expect_empty(input string tag, input logic [3:0] a,
                              input logic h);
    chk({tag, ".valid"}, 32'(instr_valid), 32'd0);
    chk({tag, ".addr"}, 32'(imem_addr), 32'(a));
    chk({tag, ".halted"}, 32'(halted), 32'(h));
  endtask

  initial begin
    mem[0] = 16'h1001;
    mem[1] = 16'h2002;
    mem[2] = 16'h3003;
    mem[3] = 16'hF000;
    for (int i = 4; i < 16; i++)
      mem[i] = 16'((i << 8) | i);

    reset = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr = '0;
    instr_ready = 1'b1;
    resume = 1'b0;

    tick;
    tick;
    expect_empty("rst", 4'd0, 1'b0);
    chk("rst.out", 32'(instr_out), 32'd0);
    chk("rst.pc", 32'(instr_pc), 32'd0);

    reset = 1'b1;
    tick; expect_word("s0", 16'h1001, 4'd0, 4'd1);
    tick; expect_word("s1", 16'h2002, 4'd1, 4'd2);

    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick; expect_word("stall", 16'h2002, 4'd1, 4'd2);
    end
    instr_ready = 1'b1;
    tick; expect_word("s2", 16'h3003, 4'd2, 4'd3);

    tick; expect_word("hw", 16'hF000, 4'd3, 4'd4);
    tick; expect_empty("h0", 4'd4, 1'b1);
    tick; expect_empty("h1", 4'd4, 1'b1);
    resume = 1'b1;
    tick; expect_empty("res", 4'd4, 1'b0);
    resume = 1'b0;
    tick; expect_word("s4", 16'h0404, 4'd4, 4'd5);

    instr_ready = 1'b0;
    tick; expect_word("bp", 16'h0404, 4'd4, 4'd5);
    redirect_valid = 1'b1;
    redirect_addr = 4'hA;
    tick; expect_empty("rd", 4'hA, 1'b0);
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    tick; expect_word("rdA", 16'h0A0A, 4'hA, 4'hB);

    for (int p = 11; p < 16; p++) begin
      tick;
      expect_word("wrap", 16'((p << 8) | p), 4'(p), 4'(p + 1));
    end
    tick; expect_word("w0", 16'h1001, 4'd0, 4'd1);

    redirect_valid = 1'b1;
    redirect_addr = 4'd3;
    tick; expect_empty("rd3", 4'd3, 1'b0);
    redirect_valid = 1'b0;
    tick; expect_word("hw2", 16'hF000, 4'd3, 4'd4);
    tick; expect_empty("h2", 4'd4, 1'b1);
    redirect_valid = 1'b1;
    redirect_addr = 4'd5;
    tick; expect_empty("rdh", 4'd5, 1'b0);
    redirect_valid = 1'b0;
    tick; expect_word("s5", 16'h0505, 4'd5, 4'd6);

    instr_ready = 1'b0;
    tick; expect_word("bp2", 16'h0505, 4'd5, 4'd6);
    reset = 1'b0;
    redirect_valid = 1'b1;
    redirect_addr = 4'd9;
    tick; expect_empty("rr", 4'd0, 1'b0);
    chk("rr.out", 32'(instr_out), 32'd0);
    chk("rr.pc", 32'(instr_pc), 32'd0);
    reset = 1'b1;
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    tick; expect_word("rr1", 16'h1001, 4'd0, 4'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
